// File: rtl/lcd_timing_pkg.sv
// -----------------------------------------------------------------------------
// lcd_timing_pkg
// Shared constants for the 480x272 parallel-RGB LCD timing generator: default
// visible/porch/sync lengths for each axis, the derived line and frame totals,
// and a helper that sums an axis into its total period.
// -----------------------------------------------------------------------------
package lcd_timing_pkg;

   localparam int unsigned LCD_H_DISPLAY = 480;
   localparam int unsigned LCD_H_FRONT   = 2;
   localparam int unsigned LCD_H_SYNC    = 41;
   localparam int unsigned LCD_H_BACK    = 2;

   localparam int unsigned LCD_V_DISPLAY = 272;
   localparam int unsigned LCD_V_FRONT   = 2;
   localparam int unsigned LCD_V_SYNC    = 10;
   localparam int unsigned LCD_V_BACK    = 2;

   localparam int unsigned LCD_X_WIDTH   = 10;
   localparam int unsigned LCD_Y_WIDTH   = 10;

   function automatic int unsigned axis_total(input int unsigned display,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
      return display + front + sync + back;
   endfunction

   localparam int unsigned LCD_H_TOTAL =
      axis_total(LCD_H_DISPLAY, LCD_H_FRONT, LCD_H_SYNC, LCD_H_BACK);
   localparam int unsigned LCD_V_TOTAL =
      axis_total(LCD_V_DISPLAY, LCD_V_FRONT, LCD_V_SYNC, LCD_V_BACK);

endpackage

// File: rtl/lcd_timing_axis.sv
// -----------------------------------------------------------------------------
// lcd_timing_axis
// One timing axis: a wrapping counter 0..TOTAL-1 plus decode of the sync
// window and the visible window for the current count. Used once for the
// horizontal axis (pixels) and once for the vertical axis (lines).
//
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   clr_i        synchronous clear of the counter (has priority over en_i)
//   en_i         advance the counter by one this clock
//   cnt_o        current count
//   wrap_o       en_i while the count is TOTAL-1 (counter returns to 0 next)
//   sync_o       count lies in [DISPLAY+FRONT, DISPLAY+FRONT+SYNC)
//   visible_o    count lies in [0, DISPLAY)
// -----------------------------------------------------------------------------
module lcd_timing_axis
   import lcd_timing_pkg::*;
#(
   parameter int unsigned DISPLAY = LCD_H_DISPLAY,
   parameter int unsigned FRONT   = LCD_H_FRONT,
   parameter int unsigned SYNC    = LCD_H_SYNC,
   parameter int unsigned BACK    = LCD_H_BACK,
   parameter int unsigned CW      = $clog2(axis_total(DISPLAY, FRONT, SYNC, BACK))
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [CW-1:0] cnt_o,
   output logic          wrap_o,
   output logic          sync_o,
   output logic          visible_o
);

   localparam int unsigned TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);

   // Window bounds are held one bit wider than the counter so that a sync
   // window ending exactly at 2**CW (zero back porch) still compares correctly.
   localparam logic [CW:0] LAST       = (CW+1)'(TOTAL - 1);
   localparam logic [CW:0] DISP_END   = (CW+1)'(DISPLAY);
   localparam logic [CW:0] SYNC_START = (CW+1)'(DISPLAY + FRONT);
   localparam logic [CW:0] SYNC_END   = (CW+1)'(DISPLAY + FRONT + SYNC);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW:0]   cnt_w;

   assign cnt_w     = {1'b0, cnt_q};
   assign wrap_o    = en_i && (cnt_w == LAST);
   assign sync_o    = (cnt_w >= SYNC_START) && (cnt_w < SYNC_END);
   assign visible_o = (cnt_w < DISP_END);
   assign cnt_o     = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lcd_480_272_timing.sv
// -----------------------------------------------------------------------------
// lcd_480_272_timing
// Video timing generator for the 480x272 parallel-RGB LCD, clocked by the
// pixel clock from the PLL. Produces registered HSYNC/VSYNC (active-low),
// data enable, pixel coordinates and a one-clock frame_start pulse. Every
// output describes the counter state of the previous clock.
//
// Ports:
//   clk          pixel clock (PLL CLKOUT0)
//   rst_n        asynchronous active-low reset
//   pll_lock     PLL lock, only present with LCD_TIMING_LOCK_GATE_EN defined
//   hsync        horizontal sync, active-low
//   vsync        vertical sync, active-low
//   display_on   data enable, high in the visible area
//   x, y         pixel column / row (counter values, also outside visible area)
//   frame_start  one-clock pulse for pixel (0,0)
//
// Build option:
//   LCD_TIMING_LOCK_GATE_EN  adds pll_lock; timing is held in reset state
//                            until the (2-flop synchronized) lock is high.
// -----------------------------------------------------------------------------
module lcd_480_272_timing
   import lcd_timing_pkg::*;
#(
   parameter int unsigned H_DISPLAY = LCD_H_DISPLAY,
   parameter int unsigned H_FRONT   = LCD_H_FRONT,
   parameter int unsigned H_SYNC    = LCD_H_SYNC,
   parameter int unsigned H_BACK    = LCD_H_BACK,
   parameter int unsigned V_DISPLAY = LCD_V_DISPLAY,
   parameter int unsigned V_FRONT   = LCD_V_FRONT,
   parameter int unsigned V_SYNC    = LCD_V_SYNC,
   parameter int unsigned V_BACK    = LCD_V_BACK,
   parameter int unsigned X_WIDTH   = LCD_X_WIDTH,
   parameter int unsigned Y_WIDTH   = LCD_Y_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef LCD_TIMING_LOCK_GATE_EN
   input  logic               pll_lock,
`endif
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output logic [X_WIDTH-1:0] x,
   output logic [Y_WIDTH-1:0] y,
   output logic               frame_start
);

   localparam int unsigned H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int unsigned V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
   localparam int unsigned HCW     = $clog2(H_TOTAL);
   localparam int unsigned VCW     = $clog2(V_TOTAL);

   if (X_WIDTH < $clog2(H_DISPLAY)) begin : g_x_width_check
      $error("X_WIDTH is too narrow to address H_DISPLAY columns");
   end
   if (Y_WIDTH < $clog2(V_DISPLAY)) begin : g_y_width_check
      $error("Y_WIDTH is too narrow to address V_DISPLAY rows");
   end

   // run: timing is allowed to advance this clock
   logic run;

`ifdef LCD_TIMING_LOCK_GATE_EN
   logic lock_s1_q, lock_s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_s1_q <= 1'b0;
         lock_s2_q <= 1'b0;
      end else begin
         lock_s1_q <= pll_lock;
         lock_s2_q <= lock_s1_q;
      end
   end

   assign run = lock_s2_q;
`else
   assign run = 1'b1;
`endif

   logic [HCW-1:0] h_cnt;
   logic [VCW-1:0] v_cnt;
   logic           h_wrap, h_sync_win, h_vis;
   logic           v_wrap_unused, v_sync_win, v_vis;

   // Both counters are cleared while stopped, so counting always resumes at (0,0).
   lcd_timing_axis #(
      .DISPLAY (H_DISPLAY),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .CW      (HCW)
   ) u_h_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (!run),
      .en_i      (run),
      .cnt_o     (h_cnt),
      .wrap_o    (h_wrap),
      .sync_o    (h_sync_win),
      .visible_o (h_vis)
   );

   // The V end-of-frame wrap coincides with the H wrap; nothing downstream needs it.
   lcd_timing_axis #(
      .DISPLAY (V_DISPLAY),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .CW      (VCW)
   ) u_v_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (!run),
      .en_i      (h_wrap),
      .cnt_o     (v_cnt),
      .wrap_o    (v_wrap_unused),
      .sync_o    (v_sync_win),
      .visible_o (v_vis)
   );

   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               de_q, de_d;
   logic [X_WIDTH-1:0] x_q, x_d;
   logic [Y_WIDTH-1:0] y_q, y_d;
   logic               fs_q, fs_d;

   always_comb begin
      hsync_d = ~h_sync_win;
      vsync_d = ~v_sync_win;
      de_d    = h_vis && v_vis;
      x_d     = X_WIDTH'(h_cnt);
      y_d     = Y_WIDTH'(v_cnt);
      fs_d    = (h_cnt == '0) && (v_cnt == '0);
      if (!run) begin
         hsync_d = 1'b1;
         vsync_d = 1'b1;
         de_d    = 1'b0;
         x_d     = '0;
         y_d     = '0;
         fs_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         de_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         fs_q    <= 1'b0;
      end else begin
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         x_q     <= x_d;
         y_q     <= y_d;
         fs_q    <= fs_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_480_272_timing.sv
// -----------------------------------------------------------------------------
// tb_lcd_480_272_timing
// Self-checking bench for lcd_480_272_timing. Horizontal timing uses the
// 480x272 defaults; V_DISPLAY is shortened to 16 lines (porches and sync
// stay at their defaults) so whole frames fit in a short run.
// -----------------------------------------------------------------------------
module tb_lcd_480_272_timing;

   localparam int unsigned HD = 480, HF = 2, HS = 41, HB = 2;
   localparam int unsigned VD = 16,  VF = 2, VS = 10, VB = 2;
   localparam int unsigned HT    = HD + HF + HS + HB;
   localparam int unsigned VT    = VD + VF + VS + VB;
   localparam int unsigned FRAME = HT * VT;
`ifdef LCD_TIMING_LOCK_GATE_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 0;
`endif

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [9:0] x;
      logic [9:0] y;
      logic       fs;
   } outs_t;

   typedef struct {
      int unsigned k;
      outs_t       o;
   } vec_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
`ifdef LCD_TIMING_LOCK_GATE_EN
   logic       pll_lock = 1'b1;
`endif
   logic       hsync, vsync, display_on, frame_start;
   logic [9:0] x, y;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   // k = number of output-producing edges since timing (re)started; 0 = reset values
   int unsigned k = 0;

   always #5 clk = ~clk;

   lcd_480_272_timing #(
      .V_DISPLAY (VD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef LCD_TIMING_LOCK_GATE_EN
      .pll_lock    (pll_lock),
`endif
      .hsync       (hsync),
      .vsync       (vsync),
      .display_on  (display_on),
      .x           (x),
      .y           (y),
      .frame_start (frame_start)
   );

   function automatic outs_t mk_o(input logic hs, input logic vs, input logic de,
                                  input int unsigned xx, input int unsigned yy,
                                  input logic fs);
      outs_t o;
      o.hs = hs; o.vs = vs; o.de = de;
      o.x  = 10'(xx); o.y = 10'(yy); o.fs = fs;
      return o;
   endfunction

   function automatic vec_t mk(input int unsigned kk, input logic hs, input logic vs,
                               input logic de, input int unsigned xx,
                               input int unsigned yy, input logic fs);
      vec_t v;
      v.k = kk;
      v.o = mk_o(hs, vs, de, xx, yy, fs);
      return v;
   endfunction

   // Reference: position in the frame from the edge count, then window rules.
   function automatic outs_t model(input int unsigned kk);
      int unsigned p, h, v;
      if (kk == 0) return mk_o(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      p = (kk - 1) % FRAME;
      h = p % HT;
      v = p / HT;
      return mk_o(!(h >= HD + HF && h < HD + HF + HS),
                  !(v >= VD + VF && v < VD + VF + VS),
                  (h < HD) && (v < VD), h, v, p == 0);
   endfunction

   task automatic check(input string name, input outs_t want);
      outs_t got;
      got.hs = hsync; got.vs = vsync; got.de = display_on;
      got.x  = x;     got.y  = y;     got.fs = frame_start;
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s k=%0d: got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b, want hs=%b vs=%b de=%b x=%0d y=%0d fs=%b",
                  name, k, got.hs, got.vs, got.de, got.x, got.y, got.fs,
                  want.hs, want.vs, want.de, want.x, want.y, want.fs);
      end
   endtask

   task automatic tick(input bit adv);
      @(posedge clk);
      if (adv) k++; else k = 0;
      @(negedge clk);
   endtask

   task automatic run_checked(input int unsigned n);
      repeat (n) begin
         tick(1'b1);
         check("model", model(k));
      end
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      k = 0;
      repeat (LAT) begin
         tick(1'b0);
         check("lock_sync", model(0));
      end
   endtask

   // Assert reset between clock edges, check outputs before the next edge.
   task automatic async_reset(input int unsigned hold);
      #($urandom_range(1, 3));
      rst_n = 1'b0;
      #1;
      k = 0;
      check("async_reset", model(0));
      @(negedge clk);
      repeat (hold) begin
         tick(1'b0);
         check("in_reset", model(0));
      end
      release_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  vec[19];
      outs_t first_px;
      int unsigned target;

      first_px = mk_o(1'b1, 1'b1, 1'b1, 0, 0, 1'b1);

      //            k      hs    vs    de    x    y   fs
      vec[0]  = mk(1,     1'b1, 1'b1, 1'b1, 0,   0,  1'b1);
      vec[1]  = mk(2,     1'b1, 1'b1, 1'b1, 1,   0,  1'b0);
      vec[2]  = mk(480,   1'b1, 1'b1, 1'b1, 479, 0,  1'b0);
      vec[3]  = mk(481,   1'b1, 1'b1, 1'b0, 480, 0,  1'b0);
      vec[4]  = mk(482,   1'b1, 1'b1, 1'b0, 481, 0,  1'b0);
      vec[5]  = mk(483,   1'b0, 1'b1, 1'b0, 482, 0,  1'b0);
      vec[6]  = mk(523,   1'b0, 1'b1, 1'b0, 522, 0,  1'b0);
      vec[7]  = mk(524,   1'b1, 1'b1, 1'b0, 523, 0,  1'b0);
      vec[8]  = mk(525,   1'b1, 1'b1, 1'b0, 524, 0,  1'b0);
      vec[9]  = mk(526,   1'b1, 1'b1, 1'b1, 0,   1,  1'b0);
      vec[10] = mk(8355,  1'b1, 1'b1, 1'b1, 479, 15, 1'b0);
      vec[11] = mk(8401,  1'b1, 1'b1, 1'b0, 0,   16, 1'b0);
      vec[12] = mk(9450,  1'b1, 1'b1, 1'b0, 524, 17, 1'b0);
      vec[13] = mk(9451,  1'b1, 1'b0, 1'b0, 0,   18, 1'b0);
      vec[14] = mk(9933,  1'b0, 1'b0, 1'b0, 482, 18, 1'b0);
      vec[15] = mk(14700, 1'b1, 1'b0, 1'b0, 524, 27, 1'b0);
      vec[16] = mk(14701, 1'b1, 1'b1, 1'b0, 0,   28, 1'b0);
      vec[17] = mk(15750, 1'b1, 1'b1, 1'b0, 524, 29, 1'b0);
      vec[18] = mk(15751, 1'b1, 1'b1, 1'b1, 0,   0,  1'b1);

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_state", model(0));
      release_reset();

      // Table walk through one full frame and into the next
      for (int i = 0; i < 19; i++) begin
         while (k < vec[i].k) begin
            tick(1'b1);
            if (k < vec[i].k) check("model", model(k));
         end
         check($sformatf("vec%0d", i), vec[i].o);
      end

      // Reset asserted at line 20, pixel 200 of the second frame
      target = FRAME + 20 * HT + 200 + 1;
      run_checked(target - k);
      check("line20_px200", mk_o(1'b1, 1'b0, 1'b0, 200, 20, 1'b0));
      async_reset(2);
      tick(1'b1);
      check("restart_after_reset", first_px);
      run_checked(600);

      // Random run lengths with randomly timed reset pulses
      for (int r = 0; r < 6; r++) begin
         run_checked($urandom_range(1, 3000));
         async_reset($urandom_range(1, 3));
         tick(1'b1);
         check("restart_random", first_px);
      end

`ifdef LCD_TIMING_LOCK_GATE_EN
      // Lock loss mid-frame: two more edges advance, third shows reset values
      run_checked(700);
      pll_lock = 1'b0;
      tick(1'b1); check("lock_drop_a", model(k));
      tick(1'b1); check("lock_drop_b", model(k));
      tick(1'b0); check("lock_lost", model(0));
      repeat (1000) begin
         tick(1'b0);
         check("lock_low", model(0));
      end
      pll_lock = 1'b1;
      tick(1'b0); check("lock_rise_1", model(0));
      tick(1'b0); check("lock_rise_2", model(0));
      tick(1'b1); check("lock_frame_start", first_px);
      run_checked(200);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
